// File: rtl/uart_tx_serializer_pkg.sv
// Shared types for the UART transmit path: FSM state encoding and divider width.
package uart_tx_serializer_pkg;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..divider and strobes bit_done_o on the last cycle of each bit.
module uart_baud_counter
  import uart_tx_serializer_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] divider_i,
  output logic             bit_done_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign bit_done_o = (cnt_q == divider_i);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear_i || bit_done_o) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Transmit-only UART: start bit, WIDTH data bits LSB-first, stop bit, run-time bit period.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] clock_divider,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  output logic             data_ready,
  output logic             tx
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tx_q, tx_d;
  logic             rdy_q, rdy_d;
  logic             bit_done;

  // Counter is held at zero while idle so the start bit gets a full period.
  uart_baud_counter u_baud (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_i    (state_q == ST_IDLE),
    .divider_i  (div_q),
    .bit_done_o (bit_done)
  );

  // Outputs are computed from the next state so tx/data_ready come straight from flops.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    div_d   = div_q;
    tx_d    = tx_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d  = 1'b1;
        rdy_d = 1'b1;
        if (write_en) begin
          shift_d = data_in;
          div_d   = clock_divider;
          idx_d   = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
          rdy_d   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            tx_d  = shift_d[0];
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx         = tx_q;
  assign data_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table vectors, corner sequences, random frames.
module tb_uart_tx_serializer;

  localparam int W = 8;

  logic         clock;
  logic         reset_n;
  logic [15:0]  clock_divider;
  logic [W-1:0] data_in;
  logic         write_en;
  logic         data_ready;
  logic         tx;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_serializer #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .clock_divider (clock_divider),
    .data_in       (data_in),
    .write_en      (write_en),
    .data_ready    (data_ready),
    .tx            (tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic        hold;
    logic        perturb;
    logic [9:0]  exp_sym;   // symbol i of the frame (start, d0..d7, stop)
    int          exp_len;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: the frame is WIDTH+2 symbols, each held for div+1 cycles.
  function automatic logic [9:0] model_syms(input logic [7:0] d);
    logic [9:0] s;
    s[0] = 1'b0;
    for (int i = 0; i < W; i++) s[i+1] = d[i];
    s[9] = 1'b1;
    return s;
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!data_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (!data_ready) chk({nm, "_idle_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int bitlen;
    bitlen = int'(v.div) + 1;
    wait_idle(nm);
    @(negedge clock);
    write_en      = 1'b1;
    data_in       = v.data;
    clock_divider = v.div;
    @(negedge clock);
    if (!v.hold) write_en = 1'b0;
    for (int c = 0; c < v.exp_len; c++) begin
      chk($sformatf("%s_tx_c%0d", nm, c), int'(tx), int'(v.exp_sym[c / bitlen]));
      chk($sformatf("%s_rdy_c%0d", nm, c), int'(data_ready), 0);
      if (v.perturb && c == 4) begin
        data_in       = 8'h00;
        clock_divider = 16'd5;
      end
      @(negedge clock);
    end
    chk({nm, "_idle_rdy"}, int'(data_ready), 1);
    chk({nm, "_idle_tx"}, int'(tx), 1);
    @(negedge clock);
    if (v.hold) begin
      chk({nm, "_b2b_tx"}, int'(tx), 0);
      chk({nm, "_b2b_rdy"}, int'(data_ready), 0);
      write_en = 1'b0;
    end
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    reset_n       = 1'b0;
    write_en      = 1'b0;
    data_in       = '0;
    clock_divider = '0;

    // Reset state and idle behaviour
    #12;
    chk("rst_tx", int'(tx), 1);
    chk("rst_rdy", int'(data_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_tx", int'(tx), 1);
      chk("idle_rdy", int'(data_ready), 1);
    end

    tbl[0] = '{div: 16'd1, data: 8'hAA, hold: 1'b1, perturb: 1'b0, exp_sym: 10'h354, exp_len: 20};
    tbl[1] = '{div: 16'd0, data: 8'h01, hold: 1'b0, perturb: 1'b0, exp_sym: 10'h202, exp_len: 10};
    tbl[2] = '{div: 16'd2, data: 8'h55, hold: 1'b0, perturb: 1'b1, exp_sym: 10'h2AA, exp_len: 30};
    tbl[3] = '{div: 16'd3, data: 8'hFF, hold: 1'b0, perturb: 1'b0, exp_sym: 10'h3FE, exp_len: 40};
    tbl[4] = '{div: 16'd0, data: 8'h00, hold: 1'b1, perturb: 1'b0, exp_sym: 10'h200, exp_len: 10};
    for (int i = 0; i < 5; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Reset during data bit 3 (div=1: bit 3 spans frame cycles 8..9)
    wait_idle("rstmid");
    @(negedge clock);
    write_en      = 1'b1;
    data_in       = 8'hA5;
    clock_divider = 16'd1;
    @(negedge clock);
    write_en = 1'b0;
    repeat (8) @(negedge clock);
    chk("rstmid_bit3_tx", int'(tx), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_tx", int'(tx), 1);
    chk("rstmid_rdy", int'(data_ready), 1);
    @(negedge clock);
    reset_n = 1'b1;
    rv = '{div: 16'd1, data: 8'hC3, hold: 1'b0, perturb: 1'b0, exp_sym: 10'h386, exp_len: 20};
    run_frame(rv, "post_rst");

    // Random frames against the symbol-level model
    for (int i = 0; i < 20; i++) begin
      rv.div     = 16'($urandom_range(0, 4));
      rv.data    = 8'($urandom);
      rv.hold    = 1'($urandom_range(0, 1));
      rv.perturb = 1'($urandom_range(0, 1));
      rv.exp_sym = model_syms(rv.data);
      rv.exp_len = (W + 2) * (int'(rv.div) + 1);
      run_frame(rv, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
